// File: rtl/matriz_leds_scan.sv
// Self-timed scanner for a multiplexed LED matrix with a double-buffered frame.
// The back buffer is copied to the front buffer only when the scan wraps, so a frame never tears.
module matriz_leds_scan #(
  parameter int LINHAS   = 7,
  parameter int COLUNAS  = 5,
  parameter int PRESCALE = 50000,
  localparam int COL_W   = $clog2(COLUNAS)
) (
  input  logic               clock_in,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               wr_en,
  input  logic [COL_W-1:0]   wr_col,
  input  logic [LINHAS-1:0]  wr_data,
  input  logic               commit_req,
  output logic               commit_ack,
  output logic               frame_start,
  output logic [COLUNAS-1:0] colunas,
  output logic [LINHAS-1:0]  linhas
);

  localparam int PRESC_W = $clog2(PRESCALE);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               pending_q, pending_d;
  logic [LINHAS-1:0]  front_q [COLUNAS];
  logic [LINHAS-1:0]  front_d [COLUNAS];
  logic [LINHAS-1:0]  back_q  [COLUNAS];
  logic [LINHAS-1:0]  back_d  [COLUNAS];
  logic [COLUNAS-1:0] colunas_q, colunas_d;
  logic [LINHAS-1:0]  linhas_q, linhas_d;

  logic tick;
  logic last_col;
  logic boundary;
  logic do_commit;

  always_comb begin
    tick      = enable && (presc_q == PRESC_W'(PRESCALE - 1));
    last_col  = (col_q == COL_W'(COLUNAS - 1));
    boundary  = tick && last_col;
    do_commit = boundary && (pending_q || commit_req);

    presc_d = '0;
    col_d   = '0;
    if (enable) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      col_d   = col_q;
      if (tick) begin
        col_d = last_col ? '0 : col_q + 1'b1;
      end
    end

    // Write lands in back_d before the copy, so a same-cycle write is part of the committed frame.
    back_d = back_q;
    if (wr_en && (32'(wr_col) < COLUNAS)) begin
      back_d[wr_col] = wr_data;
    end

    front_d = front_q;
    if (do_commit) begin
      front_d = back_d;
    end

    pending_d = (pending_q || commit_req) && !do_commit;

    // Outputs follow the post-edge column and frame, so a new frame shows from column 0 at once.
    colunas_d = '1;
    linhas_d  = '0;
    if (enable) begin
      colunas_d = ~(COLUNAS'(1) << col_d);
      linhas_d  = front_d[col_d];
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= '0;
      col_q     <= '0;
      pending_q <= 1'b0;
      colunas_q <= '1;
      linhas_q  <= '0;
      for (int i = 0; i < COLUNAS; i++) begin
        front_q[i] <= '0;
        back_q[i]  <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      col_q     <= col_d;
      pending_q <= pending_d;
      colunas_q <= colunas_d;
      linhas_q  <= linhas_d;
      for (int i = 0; i < COLUNAS; i++) begin
        front_q[i] <= front_d[i];
        back_q[i]  <= back_d[i];
      end
    end
  end

  assign colunas     = colunas_q;
  assign linhas      = linhas_q;
  assign frame_start = boundary;
  assign commit_ack  = do_commit;

endmodule

// File: tb/tb_matriz_leds_scan.sv
// Bench for matriz_leds_scan: directed scenarios plus random traffic, every cycle compared
// against a frame-level model that derives the scan position from a count of enabled cycles.
module tb_matriz_leds_scan;

  localparam int L = 7;
  localparam int C = 5;
  localparam int P = 4;

  logic         clock_in = 1'b0;
  logic         reset_n  = 1'b0;
  logic         enable   = 1'b0;
  logic         wr_en    = 1'b0;
  logic [2:0]   wr_col   = '0;
  logic [L-1:0] wr_data  = '0;
  logic         commit_req = 1'b0;
  logic         commit_ack;
  logic         frame_start;
  logic [C-1:0] colunas;
  logic [L-1:0] linhas;

  matriz_leds_scan #(.LINHAS(L), .COLUNAS(C), .PRESCALE(P)) dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .enable      (enable),
    .wr_en       (wr_en),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .commit_req  (commit_req),
    .commit_ack  (commit_ack),
    .frame_start (frame_start),
    .colunas     (colunas),
    .linhas      (linhas)
  );

  always #5 clock_in = ~clock_in;

  int checks = 0;
  int errors = 0;
  int acks_seen = 0;

  // Model: n = enabled cycles since the scan last restarted; the display position is n/P mod C.
  int           n = 0;
  logic [L-1:0] m_front [C];
  logic [L-1:0] m_back  [C];
  bit           m_pend = 1'b0;
  logic [C-1:0] exp_col = '1;
  logic [L-1:0] exp_lin = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    n = 0;
    m_pend = 1'b0;
    for (int i = 0; i < C; i++) begin
      m_front[i] = '0;
      m_back[i]  = '0;
    end
    exp_col = '1;
    exp_lin = '0;
  endtask

  // Entered 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic do_cycle(input bit en, input bit we, input logic [2:0] wc,
                          input logic [L-1:0] wd, input bit cr);
    bit bnd;
    bit ack;
    int col;
    enable = en; wr_en = we; wr_col = wc; wr_data = wd; commit_req = cr;
    @(negedge clock_in);
    check("colunas", 32'(colunas), 32'(exp_col));
    check("linhas", 32'(linhas), 32'(exp_lin));
    bnd = en && ((n % (P * C)) == (P * C - 1));
    ack = bnd && (m_pend || cr);
    check("frame_start", 32'(frame_start), 32'(bnd));
    check("commit_ack", 32'(commit_ack), 32'(ack));
    if (commit_ack) acks_seen++;
    @(posedge clock_in);
    #1;
    if (we && (int'(wc) < C)) m_back[wc] = wd;
    m_pend = m_pend || cr;
    if (ack) begin
      for (int i = 0; i < C; i++) m_front[i] = m_back[i];
      m_pend = 1'b0;
    end
    n = en ? n + 1 : 0;
    if (en) begin
      col = (n / P) % C;
      exp_col = ~(5'b00001 << col);
      exp_lin = m_front[col];
    end else begin
      exp_col = '1;
      exp_lin = '0;
    end
  endtask

  // Asserts reset between edges and checks the outputs blank without waiting for a clock.
  task automatic do_reset();
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_colunas", 32'(colunas), 32'h1F);
    check("rst_linhas", 32'(linhas), 32'h0);
    check("rst_ack", 32'(commit_ack), 32'h0);
    check("rst_fs", 32'(frame_start), 32'h0);
    model_clear();
    @(posedge clock_in);
    #1;
    check("rst_hold_colunas", 32'(colunas), 32'h1F);
    @(posedge clock_in);
    #3;
    reset_n = 1'b1;
  endtask

  task automatic idle(input int cycles, input bit en);
    for (int i = 0; i < cycles; i++) do_cycle(en, 1'b0, 3'd0, '0, 1'b0);
  endtask

  int acks_before;

  initial begin
    model_clear();
    @(posedge clock_in);
    #1;
    do_reset();
    $display("phase reset done checks=%0d", checks);

    idle(45, 1'b1);
    $display("phase scan done checks=%0d", checks);

    for (int i = 0; i < C; i++) do_cycle(1'b1, 1'b1, 3'(i), 7'(1 << i), 1'b0);
    idle(3, 1'b1);
    do_cycle(1'b1, 1'b0, 3'd0, '0, 1'b1);
    do_cycle(1'b1, 1'b0, 3'd0, '0, 1'b1);
    idle(50, 1'b1);
    $display("phase commit done checks=%0d acks=%0d", checks, acks_seen);

    while ((n % (P * C)) != (P * C - 1)) idle(1, 1'b1);
    do_cycle(1'b1, 1'b1, 3'd4, 7'h7F, 1'b1);
    idle(25, 1'b1);
    $display("phase same-cycle done checks=%0d acks=%0d", checks, acks_seen);

    idle(7, 1'b1);
    do_cycle(1'b0, 1'b1, 3'd5, 7'h55, 1'b1);
    do_cycle(1'b0, 1'b1, 3'd2, 7'h2A, 1'b0);
    idle(4, 1'b0);
    idle(45, 1'b1);
    $display("phase disable done checks=%0d acks=%0d", checks, acks_seen);

    idle(3, 1'b1);
    do_cycle(1'b1, 1'b1, 3'd1, 7'h33, 1'b1);
    idle(2, 1'b1);
    do_reset();
    acks_before = acks_seen;
    idle(60, 1'b1);
    check("no_ack_after_reset", 32'(acks_seen), 32'(acks_before));
    $display("phase reset-pending done checks=%0d", checks);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) begin
        do_reset();
      end else begin
        do_cycle($urandom_range(15) != 0, 1'($urandom), 3'($urandom),
                 7'($urandom), $urandom_range(24) == 0);
      end
    end
    $display("phase random done checks=%0d acks=%0d", checks, acks_seen);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
